srff_bank: RTL and testbench
============================

SRFF_BANK -- requirements
Module: srff_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of independent SR channels (1..64).
REQ-002 SHALL have parameter CONFLICT_MODE, default 0: S&R resolution (0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle).
REQ-003 SHALL have parameter EDGE_MODE, default 0: 0 = s/r level-sensitive, 1 = s/r act only on their 0->1 transition.
REQ-004 SHALL have parameter INIT, default all-zero, WIDTH bits: value q takes under reset.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port preset, input, WIDTH bits: synchronous per-channel preset, active-low (bit low forces that channel to 1).
REQ-008 SHALL have port s, input, WIDTH bits: per-channel set request.
REQ-009 SHALL have port r, input, WIDTH bits: per-channel reset request.
REQ-010 SHALL have port load, input, 1 bit: synchronous bulk-load strobe.
REQ-011 SHALL have port load_data, input, WIDTH bits: value written to q when load is high.
REQ-012 SHALL have port q, output, WIDTH bits: registered channel state.
REQ-013 SHALL have port q_changed, output, 1 bit: registered pulse, high for one cycle after any q bit changed.
REQ-014 SHALL have port q_count, output, clog2(WIDTH+1) bits: registered count of ones in q.

Function
REQ-015 Per-clock priority SHALL be: reset > load > preset (per bit) > s/r resolution > hold.
REQ-016 load high SHALL set q <= load_data for all bits, ignoring preset, s, r that cycle.
REQ-017 With load low, preset[i]=0 SHALL set q[i] <= 1 regardless of s[i], r[i].
REQ-018 Otherwise, for effective requests se[i], re[i]: se only -> 1; re only -> 0; neither -> hold.
REQ-019 se&re SHALL give: mode 0 hold; mode 1 -> 1; mode 2 -> 0; mode 3 -> ~q[i].
REQ-020 EDGE_MODE=0: se = s, re = r.
REQ-021 EDGE_MODE=1: se = s & ~s_d, re = r & ~r_d, where s_d/r_d are s/r registered each cycle (including cycles where load or preset win).
REQ-022 EDGE_MODE=1: a request held high SHALL act exactly once, on the first cycle it is sampled high.
REQ-023 Latency: s/r/preset/load sampled at edge N SHALL be visible on q after edge N (one cycle).
REQ-024 q_count SHALL equal popcount of q in the same cycle (computed from next-state, registered with q).
REQ-025 q_changed SHALL be 1 in the cycle after an edge where q's next value differed from its current value, else 0.
REQ-026 Channels SHALL be fully independent; no cross-channel interaction except load, q_count, q_changed.
REQ-027 No X propagation: all outputs SHALL be defined from reset onward.

Reset
REQ-028 reset high SHALL immediately (without clk) force q = INIT, q_count = popcount(INIT), q_changed = 0, s_d = 0, r_d = 0.
REQ-029 Reset mid-operation SHALL discard any pending edge history; first cycle after release treats s/r high as a new edge (EDGE_MODE=1).
REQ-030 Deassertion of reset SHALL not by itself assert q_changed.

Verification
REQ-031 WIDTH=8, INIT=0, mode 0: s=0x0F one cycle -> q=0x0F, q_count=4, q_changed=1 next cycle then 0; s=r=0xFF -> q stays 0x0F, q_changed=0.
REQ-032 Modes 1/2/3 each with q=0x0F, s=r=0xFF one cycle -> q=0xFF / 0x00 / 0xF0; q_count 8 / 0 / 4.
REQ-033 EDGE_MODE=1: hold s[0]=1 for 5 cycles with r[0] pulsed at cycle 3 -> q[0] = 1 after cycle 1, 0 after cycle 3, stays 0 through cycle 5.
REQ-034 Priority: load=1, load_data=0xA5, preset=0x00, s=0xFF -> q=0xA5; next cycle load=0, preset=0xFE, r=0xFF -> q=0x01.
REQ-035 Async reset, INIT=0x3C: assert reset between clock edges while q=0xFF -> q=0x3C, q_count=4, q_changed=0 before next clk edge; held through edges with s=0xFF -> no change.
REQ-036 Random s/r/preset/load for 10k cycles against a per-bit reference model, checking q, q_count, q_changed every cycle, for all four modes and both EDGE_MODE values.

Source files
------------

// File: rtl/srff_bank.sv
// ----------------------------------------------------------------------------
// srff_bank
//   A bank of WIDTH independent set/reset flip-flops sharing one clock, one
//   asynchronous reset and one bulk-load strobe. Each channel resolves its
//   own set/reset request. A conflicting request is resolved by
//   CONFLICT_MODE. EDGE_MODE selects level or rising-edge request
//   qualification. The bank also reports a registered popcount of its state
//   and a one-cycle pulse whenever any channel changed.
//
// Parameters
//   WIDTH          number of channels (1..64)
//   CONFLICT_MODE  s&r resolution: 0 hold, 1 set-dominant, 2 reset-dominant,
//                  3 toggle
//   EDGE_MODE      0 level-sensitive s/r, 1 s/r act on 0->1 transition only
//   INIT           value of q while reset is asserted
//
// Ports
//   clk        rising-edge clock for all state
//   reset      asynchronous active-high reset
//   preset     per-channel synchronous preset, active-low (forces q[i] to 1)
//   s, r       per-channel set / reset requests
//   load       synchronous bulk-load strobe (highest synchronous priority)
//   load_data  value written to q when load is high
//   q          registered channel state
//   q_changed  registered pulse, high the cycle after any q bit changed
//   q_count    registered popcount of q
// ----------------------------------------------------------------------------
module srff_bank #(
    parameter int unsigned      WIDTH         = 8,
    parameter int unsigned      CONFLICT_MODE = 0,
    parameter int unsigned      EDGE_MODE     = 0,
    parameter logic [WIDTH-1:0] INIT          = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             preset,
    input  logic [WIDTH-1:0]             s,
    input  logic [WIDTH-1:0]             r,
    input  logic                         load,
    input  logic [WIDTH-1:0]             load_data,
    output logic [WIDTH-1:0]             q,
    output logic                         q_changed,
    output logic [$clog2(WIDTH+1)-1:0]   q_count
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    // Number of ones in a channel vector.
    function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            acc = acc + CNT_W'(v[i]);
        end
        return acc;
    endfunction

    localparam logic [CNT_W-1:0] INIT_COUNT = popcount(INIT);

    // Effective (qualified) set / reset requests.
    logic [WIDTH-1:0] se;
    logic [WIDTH-1:0] re;

    logic [WIDTH-1:0] q_next;
    logic [CNT_W-1:0] q_count_next;
    logic             changed_next;

    // Request qualification: edge mode keeps a one-cycle history of s/r that
    // is updated every cycle, whatever won priority, and is cleared by reset
    // so a request already high at release counts as a fresh edge.
    if (EDGE_MODE == 1) begin : g_edge
        logic [WIDTH-1:0] s_d;
        logic [WIDTH-1:0] r_d;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s_d <= '0;
                r_d <= '0;
            end else begin
                s_d <= s;
                r_d <= r;
            end
        end

        assign se = s & ~s_d;
        assign re = r & ~r_d;
    end else begin : g_level
        assign se = s;
        assign re = r;
    end

    // Next-state: load > preset (per bit) > s/r resolution > hold.
    always_comb begin
        q_next = q;
        if (load) begin
            q_next = load_data;
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (!preset[i]) begin
                    q_next[i] = 1'b1;
                end else begin
                    unique case ({se[i], re[i]})
                        2'b10:   q_next[i] = 1'b1;
                        2'b01:   q_next[i] = 1'b0;
                        2'b11: begin
                            case (CONFLICT_MODE)
                                1:       q_next[i] = 1'b1;
                                2:       q_next[i] = 1'b0;
                                3:       q_next[i] = ~q[i];
                                default: q_next[i] = q[i];
                            endcase
                        end
                        default: q_next[i] = q[i];
                    endcase
                end
            end
        end
    end

    // Status derived from next-state so it lines up with q once registered.
    always_comb begin
        q_count_next = popcount(q_next);
        changed_next = |(q_next ^ q);
    end

    // State and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q         <= INIT;
            q_count   <= INIT_COUNT;
            q_changed <= 1'b0;
        end else begin
            q         <= q_next;
            q_count   <= q_count_next;
            q_changed <= changed_next;
        end
    end

endmodule

// File: tb/tb_srff_bank.sv
// ----------------------------------------------------------------------------
// tb_srff_bank
//   Nine srff_bank instances (WIDTH=8) share one stimulus stream:
//     0..3  level requests, CONFLICT_MODE 0..3, INIT 0x00
//     4..7  edge requests,  CONFLICT_MODE 0..3, INIT 0x00
//     8     level requests, CONFLICT_MODE 0,    INIT 0x3C
//   A per-bit reference model produces expected results that are queued when
//   stimulus is applied and popped after the clock edge.
// ----------------------------------------------------------------------------
module tb_srff_bank;

    localparam int NI = 9;

    typedef struct packed {
        logic [NI-1:0][7:0] q;
        logic [NI-1:0][3:0] cnt;
        logic [NI-1:0]      chg;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [7:0] preset;
    logic [7:0] s;
    logic [7:0] r;
    logic       load;
    logic [7:0] load_data;

    logic [7:0] dq   [NI];
    logic       dchg [NI];
    logic [3:0] dcnt [NI];

    int tests_run = 0;
    int fails     = 0;

    exp_t sb[$];

    // Reference model state
    logic [7:0] m_q  [NI];
    logic [7:0] m_sd [NI];
    logic [7:0] m_rd [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int         MODE = (g == 8) ? 0 : g % 4;
        localparam int         EDGE = (g >= 4 && g < 8) ? 1 : 0;
        localparam logic [7:0] IV   = (g == 8) ? 8'h3C : 8'h00;
        srff_bank #(
            .WIDTH(8), .CONFLICT_MODE(MODE), .EDGE_MODE(EDGE), .INIT(IV)
        ) u_dut (
            .clk(clk), .reset(reset), .preset(preset), .s(s), .r(r),
            .load(load), .load_data(load_data),
            .q(dq[g]), .q_changed(dchg[g]), .q_count(dcnt[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int mode_of(int g);
        return (g == 8) ? 0 : g % 4;
    endfunction

    function automatic bit edge_of(int g);
        return (g >= 4 && g < 8);
    endfunction

    function automatic logic [7:0] init_of(int g);
        return (g == 8) ? 8'h3C : 8'h00;
    endfunction

    function automatic logic [3:0] pc(logic [7:0] v);
        return 4'($countones(v));
    endfunction

    task automatic model_reset();
        for (int g = 0; g < NI; g++) begin
            m_q[g]  = init_of(g);
            m_sd[g] = 8'h00;
            m_rd[g] = 8'h00;
        end
    endtask

    // Advance the model by one clock with the current inputs.
    task automatic model_step(output exp_t e);
        logic [7:0] nq;
        bit         sq, rq;
        e = '0;
        for (int g = 0; g < NI; g++) begin
            if (reset) begin
                m_q[g]  = init_of(g);
                m_sd[g] = 8'h00;
                m_rd[g] = 8'h00;
                e.q[g]   = init_of(g);
                e.cnt[g] = pc(init_of(g));
                e.chg[g] = 1'b0;
            end else begin
                for (int b = 0; b < 8; b++) begin
                    sq = edge_of(g) ? (s[b] && !m_sd[g][b]) : s[b];
                    rq = edge_of(g) ? (r[b] && !m_rd[g][b]) : r[b];
                    if (load)            nq[b] = load_data[b];
                    else if (!preset[b]) nq[b] = 1'b1;
                    else if (sq && !rq)  nq[b] = 1'b1;
                    else if (rq && !sq)  nq[b] = 1'b0;
                    else if (sq && rq) begin
                        case (mode_of(g))
                            1:       nq[b] = 1'b1;
                            2:       nq[b] = 1'b0;
                            3:       nq[b] = ~m_q[g][b];
                            default: nq[b] = m_q[g][b];
                        endcase
                    end else         nq[b] = m_q[g][b];
                end
                e.chg[g] = (nq != m_q[g]);
                e.q[g]   = nq;
                e.cnt[g] = pc(nq);
                m_q[g]   = nq;
                m_sd[g]  = s;
                m_rd[g]  = r;
            end
        end
    endtask

    // Queue the model's expectation, clock once, then pop it for checking.
    task automatic cycle(output exp_t e);
        exp_t t;
        model_step(t);
        sb.push_back(t);
        @(posedge clk);
        #1;
        e = sb.pop_front();
    endtask

    task automatic idle_inputs();
        preset = 8'hFF; s = 8'h00; r = 8'h00; load = 1'b0; load_data = 8'h00;
    endtask

    task automatic test_reset();
        exp_t e;
        idle_inputs();
        reset = 1'b1;
        model_reset();
        #2;
        for (int g = 0; g < NI; g++) begin
            tests_run++;
            if (dq[g] !== init_of(g) || dcnt[g] !== pc(init_of(g)) || dchg[g] !== 1'b0) begin
                fails++;
                $display("FAIL reset_state inst%0d: q=%h cnt=%0d chg=%b, want q=%h cnt=%0d chg=0",
                         g, dq[g], dcnt[g], dchg[g], init_of(g), pc(init_of(g)));
            end
        end
        cycle(e);
        reset = 1'b0;
        cycle(e);
        for (int g = 0; g < NI; g++) begin
            tests_run++;
            if (dchg[g] !== 1'b0 || dq[g] !== init_of(g)) begin
                fails++;
                $display("FAIL reset_release inst%0d: q=%h chg=%b, want q=%h chg=0",
                         g, dq[g], dchg[g], init_of(g));
            end
        end
    endtask

    task automatic test_conflict_modes();
        exp_t       e;
        logic [7:0] xq [4];
        logic [3:0] xc [4];
        xq[0] = 8'h0F; xq[1] = 8'hFF; xq[2] = 8'h00; xq[3] = 8'hF0;
        xc[0] = 4'd4;  xc[1] = 4'd8;  xc[2] = 4'd0;  xc[3] = 4'd4;
        s = 8'h0F;
        cycle(e);
        tests_run++;
        if (dq[0] !== 8'h0F || dcnt[0] !== 4'd4 || dchg[0] !== 1'b1) begin
            fails++;
            $display("FAIL set_low_nibble: q=%h cnt=%0d chg=%b, want 0f 4 1", dq[0], dcnt[0], dchg[0]);
        end
        s = 8'h00;
        cycle(e);
        tests_run++;
        if (dq[0] !== 8'h0F || dchg[0] !== 1'b0) begin
            fails++;
            $display("FAIL changed_pulse_drop: q=%h chg=%b, want 0f 0", dq[0], dchg[0]);
        end
        s = 8'hFF; r = 8'hFF;
        cycle(e);
        for (int m = 0; m < 4; m++) begin
            tests_run++;
            if (dq[m] !== xq[m] || dcnt[m] !== xc[m] || dchg[m] !== (m != 0)) begin
                fails++;
                $display("FAIL conflict_mode%0d: q=%h cnt=%0d chg=%b, want q=%h cnt=%0d chg=%b",
                         m, dq[m], dcnt[m], dchg[m], xq[m], xc[m], (m != 0));
            end
        end
        idle_inputs();
        cycle(e);
    endtask

    task automatic test_edge_hold();
        exp_t       e;
        logic [4:0] xq0;
        xq0 = 5'b00011;    // bit c = expected q[0] after cycle c+1
        reset = 1'b1; model_reset();
        cycle(e);
        reset = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            s = 8'h01;
            r = (c == 3) ? 8'h01 : 8'h00;
            cycle(e);
            tests_run++;
            if (dq[4][0] !== xq0[c-1]) begin
                fails++;
                $display("FAIL edge_hold_c%0d: q0=%b, want %b", c, dq[4][0], xq0[c-1]);
            end
        end
        r = 8'h00;
        reset = 1'b1; model_reset();
        cycle(e);
        reset = 1'b0;
        cycle(e);
        tests_run++;
        if (dq[4][0] !== 1'b1 || dchg[4] !== 1'b1) begin
            fails++;
            $display("FAIL edge_after_reset: q0=%b chg=%b, want 1 1", dq[4][0], dchg[4]);
        end
        idle_inputs();
        cycle(e);
    endtask

    task automatic test_priority();
        exp_t e;
        load = 1'b1; load_data = 8'hA5; preset = 8'h00; s = 8'hFF; r = 8'h00;
        cycle(e);
        for (int g = 0; g < NI; g++) begin
            tests_run++;
            if (dq[g] !== 8'hA5 || dcnt[g] !== 4'd4) begin
                fails++;
                $display("FAIL load_priority inst%0d: q=%h cnt=%0d, want a5 4", g, dq[g], dcnt[g]);
            end
        end
        load = 1'b0; preset = 8'hFE; s = 8'h00; r = 8'hFF;
        cycle(e);
        for (int g = 0; g < NI; g++) begin
            tests_run++;
            if (dq[g] !== 8'h01 || dcnt[g] !== 4'd1 || dchg[g] !== 1'b1) begin
                fails++;
                $display("FAIL preset_priority inst%0d: q=%h cnt=%0d chg=%b, want 01 1 1",
                         g, dq[g], dcnt[g], dchg[g]);
            end
        end
        idle_inputs();
        cycle(e);
    endtask

    task automatic test_async_reset();
        exp_t e;
        s = 8'hFF;
        cycle(e);
        tests_run++;
        if (dq[8] !== 8'hFF) begin
            fails++;
            $display("FAIL async_pre: q=%h, want ff", dq[8]);
        end
        #3;
        reset = 1'b1; model_reset();
        #1;
        tests_run++;
        if (dq[8] !== 8'h3C || dcnt[8] !== 4'd4 || dchg[8] !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: q=%h cnt=%0d chg=%b, want 3c 4 0", dq[8], dcnt[8], dchg[8]);
        end
        for (int c = 0; c < 2; c++) begin
            cycle(e);
            tests_run++;
            if (dq[8] !== 8'h3C || dchg[8] !== 1'b0) begin
                fails++;
                $display("FAIL reset_hold_c%0d: q=%h chg=%b, want 3c 0", c, dq[8], dchg[8]);
            end
        end
        reset = 1'b0;
        idle_inputs();
        cycle(e);
    endtask

    task automatic test_random();
        exp_t e;
        int   shown = 0;
        reset = 1'b1; model_reset();
        cycle(e);
        reset = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            reset     = ($urandom_range(0, 399) == 0);
            load      = ($urandom_range(0, 15) == 0);
            load_data = 8'($urandom);
            preset    = ~8'($urandom & $urandom & $urandom);
            s         = 8'($urandom);
            r         = 8'($urandom);
            cycle(e);
            for (int g = 0; g < NI; g++) begin
                tests_run++;
                if (dq[g] !== e.q[g]) begin
                    fails++;
                    if (shown++ < 20)
                        $display("FAIL rand_q inst%0d n%0d: q=%h, want %h", g, n, dq[g], e.q[g]);
                end
                tests_run++;
                if (dcnt[g] !== e.cnt[g]) begin
                    fails++;
                    if (shown++ < 20)
                        $display("FAIL rand_cnt inst%0d n%0d: cnt=%0d, want %0d", g, n, dcnt[g], e.cnt[g]);
                end
                tests_run++;
                if (dchg[g] !== e.chg[g]) begin
                    fails++;
                    if (shown++ < 20)
                        $display("FAIL rand_chg inst%0d n%0d: chg=%b, want %b", g, n, dchg[g], e.chg[g]);
                end
            end
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_conflict_modes();
        test_edge_hold();
        test_priority();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
